// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and constants for the PWM configuration
//                sequencer and its PWM counter channel. Holds the PWM bus
//                width, the write-select encoding and the sequencer states.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_pkg;

    // Width of the PWM counter/registers and its data bus.
    localparam int PWM_W = 16;

    // Write select on the PWM channel's shared data/select bus.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CMP  = 2'd1,
        SEL_TOP  = 2'd2,
        SEL_CNT  = 2'd3
    } pwm_sel_t;

    // Sequencer states. ST_WAIT_SYNC is only reachable when the
    // period-synchronous update option is built in.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SYNC = 3'd1,
        ST_WR_TOP    = 3'd2,
        ST_WR_CMP    = 3'd3,
        ST_WR_CNT    = 3'd4,
        ST_FIN       = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_cfg_sequencer
//  Description : Accepts a (top, cmp, restart) request over valid/ready,
//                clamps cmp to top, then writes top, cmp and optionally the
//                counter (to 0) into one PWM channel, one write per cycle.
//                Sole driver of the channel's d/sel bus.
//  Option      : `define PWM_SYNC_UPDATE_EN to hold non-restart updates in
//                WAIT_SYNC until the PWM wrap edge (pwm_cnt >= pwm_top).
//  Ports       : clk          system clock, rising edge
//                rst_n        synchronous active-low reset
//                req_valid/req_ready  request handshake
//                req_top/req_cmp/req_restart  request payload
//                pwm_cnt/pwm_top      monitored PWM state (option only)
//                pwm_d/pwm_sel        registered write bus to the PWM
//                busy, done, clamped  status
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_cfg_sequencer
    import pwm_pkg::*;
#(
    parameter int W = PWM_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_top,
    input  logic [W-1:0] req_cmp,
    input  logic         req_restart,
    input  logic [W-1:0] pwm_cnt,
    input  logic [W-1:0] pwm_top,
    output logic [W-1:0] pwm_d,
    output logic [1:0]   pwm_sel,
    output logic         busy,
    output logic         done,
    output logic         clamped
);

    seq_state_t     r_state;
    logic [W-1:0]   r_top;
    logic [W-1:0]   r_cmp;
    logic           r_rst;
    logic           r_clamped;
    pwm_sel_t       r_sel;
    logic [W-1:0]   r_d;

    seq_state_t     w_state_nxt;
    pwm_sel_t       w_sel_nxt;
    logic [W-1:0]   w_d_nxt;
    logic           w_xfer;
    logic           w_clamp;
    logic [W-1:0]   w_top_nxt;
    logic [W-1:0]   w_cmp_nxt;

    assign w_xfer    = req_valid && (r_state == ST_IDLE);
    assign w_clamp   = (req_cmp > req_top);
    // Next values of the request latch; the write bus is decoded from these
    // so the top write is already on the bus in the cycle after transfer.
    assign w_top_nxt = w_xfer ? req_top : r_top;
    assign w_cmp_nxt = w_xfer ? (w_clamp ? req_top : req_cmp) : r_cmp;

`ifndef PWM_SYNC_UPDATE_EN
    // Monitored PWM state is only needed for the synchronous update option.
    logic w_unused_pwm;
    assign w_unused_pwm = ^{pwm_cnt, pwm_top};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
`ifdef PWM_SYNC_UPDATE_EN
                    // A restart forces the counter anyway, so no need to wait.
                    w_state_nxt = req_restart ? ST_WR_TOP : ST_WAIT_SYNC;
`else
                    w_state_nxt = ST_WR_TOP;
`endif
                end
            end
`ifdef PWM_SYNC_UPDATE_EN
            ST_WAIT_SYNC: begin
                if (pwm_cnt >= pwm_top) begin
                    w_state_nxt = ST_WR_TOP;
                end
            end
`endif
            ST_WR_TOP: w_state_nxt = ST_WR_CMP;
            ST_WR_CMP: w_state_nxt = r_rst ? ST_WR_CNT : ST_FIN;
            ST_WR_CNT: w_state_nxt = ST_FIN;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Write bus is decoded from the next state and registered, so it lines
    // up with the state that owns the write.
    always_comb begin
        w_sel_nxt = SEL_NONE;
        w_d_nxt   = '0;
        case (w_state_nxt)
            ST_WR_TOP: begin
                w_sel_nxt = SEL_TOP;
                w_d_nxt   = w_top_nxt;
            end
            ST_WR_CMP: begin
                w_sel_nxt = SEL_CMP;
                w_d_nxt   = w_cmp_nxt;
            end
            ST_WR_CNT: begin
                w_sel_nxt = SEL_CNT;
                w_d_nxt   = '0;
            end
            default: begin
                w_sel_nxt = SEL_NONE;
                w_d_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_top     <= '0;
            r_cmp     <= '0;
            r_rst     <= 1'b0;
            r_clamped <= 1'b0;
            r_sel     <= SEL_NONE;
            r_d       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_d     <= w_d_nxt;
            if (w_xfer) begin
                r_top     <= w_top_nxt;
                r_cmp     <= w_cmp_nxt;
                r_rst     <= req_restart;
                r_clamped <= w_clamp;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign done      = (r_state == ST_FIN);
    assign clamped   = r_clamped;
    assign pwm_sel   = r_sel;
    assign pwm_d     = r_d;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_cfg_sequencer
//  Description : Self-checking bench for pwm_cfg_sequencer with a small
//                behavioural PWM channel attached to the write bus. Expected
//                writes are queued when a request is driven and popped as the
//                sequencer produces them. Build with PWM_SYNC_UPDATE_EN to
//                exercise the period-synchronous option.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_cfg_sequencer;

    localparam int c_W = 16;

    typedef struct {
        logic           is_done;
        logic [1:0]     sel;
        logic [c_W-1:0] d;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [c_W-1:0] req_top;
    logic [c_W-1:0] req_cmp;
    logic           req_restart;
    logic [c_W-1:0] pwm_d;
    logic [1:0]     pwm_sel;
    logic           busy;
    logic           done;
    logic           clamped;

    // Behavioural PWM channel.
    logic [c_W-1:0] m_cnt = '0;
    logic [c_W-1:0] m_top = '0;
    logic [c_W-1:0] m_cmp = '0;
    logic           m_out;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pwm_cfg_sequencer #(.W(c_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_top    (req_top),
        .req_cmp    (req_cmp),
        .req_restart(req_restart),
        .pwm_cnt    (m_cnt),
        .pwm_top    (m_top),
        .pwm_d      (pwm_d),
        .pwm_sel    (pwm_sel),
        .busy       (busy),
        .done       (done),
        .clamped    (clamped)
    );

    always @(posedge clk) begin
        if (pwm_sel == 2'd2) m_top <= pwm_d;
        if (pwm_sel == 2'd1) m_cmp <= pwm_d;
        if (pwm_sel == 2'd3)       m_cnt <= pwm_d;
        else if (m_cnt >= m_top)   m_cnt <= '0;
        else                       m_cnt <= m_cnt + 1'b1;
    end
    assign m_out = (m_cnt <= m_cmp);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write or done pulse must match the queue head.
    always @(negedge clk) begin
        if (pwm_sel != 2'd0 || done) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sel",  {30'd0, pwm_sel}, {30'd0, (e.is_done ? 2'd0 : e.sel)});
                check("sb_d",    {16'd0, pwm_d},   {16'd0, e.d});
                check("sb_done", {31'd0, done},    {31'd0, e.is_done});
            end
        end
    end

    task automatic push_exp(input logic [c_W-1:0] top, input logic [c_W-1:0] cmp, input logic rs);
        logic [c_W-1:0] cm;
        cm = (cmp > top) ? top : cmp;
        sb.push_back('{1'b0, 2'd2, top});
        sb.push_back('{1'b0, 2'd1, cm});
        if (rs) sb.push_back('{1'b0, 2'd3, '0});
        sb.push_back('{1'b1, 2'd0, '0});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request; returns #1 after the transfer edge.
    task automatic send(input logic [c_W-1:0] top, input logic [c_W-1:0] cmp, input logic rs);
        for (int i = 0; i < 20 && !req_ready; i++) step();
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        push_exp(top, cmp, rs);
        req_top     = top;
        req_cmp     = cmp;
        req_restart = rs;
        req_valid   = 1'b1;
        step();
        req_valid   = 1'b0;
    endtask

    initial begin
        int hi;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_top     = '0;
        req_cmp     = '0;
        req_restart = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",   {31'd0, req_ready}, 32'd1);
        check("rst_sel",     {30'd0, pwm_sel},   32'd0);
        check("rst_d",       {16'd0, pwm_d},     32'd0);
        check("rst_busy",    {31'd0, busy},      32'd0);
        check("rst_done",    {31'd0, done},      32'd0);
        check("rst_clamped", {31'd0, clamped},   32'd0);
        rst_n = 1'b1;
        step();

        // Reset while the cmp write is on the bus.
        send(16'd11, 16'd3, 1'b1);
        check("abort_top_sel", {30'd0, pwm_sel}, 32'd2);
        step();
        check("abort_cmp_sel", {30'd0, pwm_sel}, 32'd1);
        rst_n = 1'b0;
        step();
        check("abort_sel",   {30'd0, pwm_sel},   32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_busy",  {31'd0, busy},      32'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_writes", {30'd0, pwm_sel}, 32'd0);

`ifdef PWM_SYNC_UPDATE_EN
        // Restart skips the wait; establishes top=15.
        send(16'd15, 16'd5, 1'b1);
        check("sync_rst_top", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd15});
        repeat (4) step();
        for (int i = 0; i < 40 && m_cnt != 16'd4; i++) step();
        check("sync_cnt_at_4", {16'd0, m_cnt}, 32'd4);
        send(16'd15, 16'd7, 1'b0);
        check("sync_wait_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 40 && m_cnt != 16'd15; i++) begin
            check("sync_wait_nosel", {30'd0, pwm_sel}, 32'd0);
            step();
        end
        check("sync_cnt_15", {16'd0, m_cnt}, 32'd15);
        check("sync_nosel_at_15", {30'd0, pwm_sel}, 32'd0);
        step();
        check("sync_top_after_wrap", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd15});
        check("sync_cnt_wrapped", {16'd0, m_cnt}, 32'd0);
        repeat (4) step();
`else
        // Basic sequence and attached PWM duty.
        send(16'd9, 16'd3, 1'b0);
        check("t2_top", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd9});
        check("t2_busy", {31'd0, busy}, 32'd1);
        step();
        check("t2_cmp", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd1, 16'd3});
        step();
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_fin_nosel", {30'd0, pwm_sel}, 32'd0);
        repeat (2) step();
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_out) hi++;
            step();
        end
        check("t2_pwm_high_of_10", 32'(hi), 32'd4);

        // Clamp, then clear on the next accepted request.
        send(16'd5, 16'd20, 1'b0);
        check("t3_clamped_set", {31'd0, clamped}, 32'd1);
        step();
        check("t3_cmp_clamped", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd1, 16'd5});
        repeat (2) step();
        check("t3_clamped_sticky", {31'd0, clamped}, 32'd1);
        send(16'd5, 16'd2, 1'b0);
        check("t3_clamped_clear", {31'd0, clamped}, 32'd0);
        repeat (4) step();

        // Restart sequence.
        send(16'd7, 16'd2, 1'b1);
        check("t4_top", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd7});
        step();
        check("t4_cmp", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd1, 16'd2});
        step();
        check("t4_cnt", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd3, 16'd0});
        step();
        check("t4_pwm_cnt_zero", {16'd0, m_cnt}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd1);
        repeat (2) step();

        // Valid held through busy with changing payload.
        push_exp(16'd12, 16'd4, 1'b0);
        push_exp(16'd8, 16'd6, 1'b0);
        req_top = 16'd12; req_cmp = 16'd4; req_restart = 1'b0; req_valid = 1'b1;
        step();
        check("t5_a_top", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd12});
        check("t5_ready_busy1", {31'd0, req_ready}, 32'd0);
        req_top = 16'($urandom_range(0, 65535)); req_cmp = 16'($urandom_range(0, 65535));
        step();
        check("t5_a_cmp", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd1, 16'd4});
        check("t5_ready_busy2", {31'd0, req_ready}, 32'd0);
        req_top = 16'($urandom_range(0, 65535)); req_cmp = 16'($urandom_range(0, 65535));
        req_restart = 1'b1;
        step();
        check("t5_a_done", {31'd0, done}, 32'd1);
        check("t5_ready_fin", {31'd0, req_ready}, 32'd0);
        req_top = 16'd8; req_cmp = 16'd6; req_restart = 1'b0;
        step();
        check("t5_ready_idle", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check("t5_b_top", {14'd0, pwm_sel, pwm_d}, {14'd0, 2'd2, 16'd8});
        repeat (4) step();
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
